muldiv_scheduler: RTL and testbench
===================================

MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum wait cycles for a unit done.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request from control unit.
REQ-006 SHALL have port op  input  2  00 MULT, 01 DIV, 10 DIVM, 11 reserved.
REQ-007 SHALL have ports a_in, b_in  input  WIDTH  operands (A/B registers).
REQ-008 SHALL have ports mult_start, div_start  output  1  one-cycle unit launch.
REQ-009 SHALL have ports mult_done, div_done  input  1  unit completion pulses.
REQ-010 SHALL have ports mult_hi, mult_lo, div_hi, div_lo  input  WIDTH  unit results.
REQ-011 SHALL have ports hi_w, lo_w  output  1  HI/LO register write enables.
REQ-012 SHALL have ports hi_out, lo_out  output  WIDTH  selected HI/LO write data.
REQ-013 SHALL have ports busy, done, div_zero, timeout_err, unit_abort  output  1  status/abort.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_MUL, WAIT_DIV, WRITE, ERR.
REQ-015 SHALL, in IDLE with start=1 and op!=11, latch op/a_in/b_in and enter ISSUE next cycle.
REQ-016 SHALL ignore start with op=11 (stay IDLE, no outputs).
REQ-017 SHALL ignore start while busy=1; no queuing.
REQ-018 SHALL, in ISSUE: MULT -> mult_start=1 for one cycle, go WAIT_MUL; DIV/DIVM with latched b!=0 -> div_start=1, go WAIT_DIV.
REQ-019 SHALL, in ISSUE with DIV/DIVM and latched b==0, pulse div_zero one cycle, issue no start, return IDLE, no HI/LO write.
REQ-020 SHALL count wait cycles from 0 on WAIT entry; done of the awaited unit -> capture its hi/lo, go WRITE.
REQ-021 SHALL ignore the done of the non-awaited unit.
REQ-022 SHALL, when counter reaches TIMEOUT-1 without done, go ERR; done in that same cycle wins (go WRITE).
REQ-023 SHALL, in WRITE, assert hi_w=lo_w=done=1 for exactly one cycle with captured data on hi_out/lo_out, then IDLE.
REQ-024 SHALL, in ERR, pulse timeout_err and unit_abort one cycle, no HI/LO write, then IDLE.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL give latency: start at cycle 0, unit start at cycle 1, done at cycle k -> hi_w at k+1, IDLE at k+2.
REQ-027 SHALL keep hi_out/lo_out stable outside WRITE (last captured values).

Reset
REQ-028 SHALL, on reset=0 at any time, go IDLE asynchronously, clear counter, latched operands and captured results to 0.
REQ-029 SHALL hold all outputs 0 during and after reset until a new start.
REQ-030 SHALL, on reset mid-WAIT, not produce hi_w/done for the aborted operation; a later stale unit done in IDLE is ignored.

Structure
REQ-031 SHALL place state enum, op encodings (OP_MULT, OP_DIV, OP_DIVM) and default TIMEOUT in shared package muldiv_pkg.
REQ-032 SHALL implement the wait counter as sub-module muldiv_watchdog (clear, enable, expired output).

Verification
REQ-033 SHALL test MULT a=7,b=6; mult_done 33 cycles after mult_start with lo=42,hi=0 -> one-cycle hi_w/lo_w, lo_out=42, done=1.
REQ-034 SHALL test DIV a=100,b=0 -> div_zero pulse at cycle 1, no div_start, no hi_w, busy low at cycle 2.
REQ-035 SHALL test DIV a=100,b=7, div_done with lo=14,hi=2 -> lo_out=14, hi_out=2; mult_done injected mid-wait ignored.
REQ-036 SHALL test TIMEOUT=8 with no done -> timeout_err and unit_abort pulse, no write; done on final count cycle -> WRITE instead.
REQ-037 SHALL test start during WAIT_DIV ignored, and reset=0 mid-WAIT_MUL -> IDLE, later mult_done produces no hi_w.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: definitions shared by the multiply/divide scheduler and its
// wait-cycle watchdog.
//   WIDTH_DEFAULT    default operand/result width
//   TIMEOUT_DEFAULT  default number of cycles to wait for a unit done
//   OP_*             operation encodings carried on the op input
//                    (the fourth code, 2'b11, is reserved and never accepted)
//   state_e          scheduler FSM states
package muldiv_pkg;

  localparam int WIDTH_DEFAULT   = 32;
  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVM = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_MUL = 3'd2,
    WAIT_DIV = 3'd3,
    WRITE    = 3'd4,
    ERR      = 3'd5
  } state_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: counts wait cycles while a unit result is outstanding.
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset, clears the count
//   clear_i    synchronous clear to 0 (wins over enable_i)
//   enable_i   count one cycle
//   expired_o  high while enabled and the count has reached TIMEOUT-1
module muldiv_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count saturates at LAST so expired_o cannot wrap back to low if the
  // owner is slow to react.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler: accepts MULT/DIV/DIVM requests, launches the matching
// arithmetic unit, waits (bounded by TIMEOUT) for its done pulse and writes
// the captured result into HI/LO for one cycle.
//   clk, reset                 clock, asynchronous active-low reset
//   start, op, a_in, b_in      request from control unit (one-cycle start)
//   mult_start, div_start      one-cycle unit launch pulses
//   mult_done/div_done + hi/lo unit completion pulses and results
//   hi_w, lo_w, hi_out, lo_out HI/LO write enables and write data
//   busy, done, div_zero,
//   timeout_err, unit_abort    status pulses (busy is a level)
//   dbg_state_o, dbg_op_o,
//   dbg_a_o, dbg_b_o           FSM state and latched request, for observation
// Handshake: start is only sampled in IDLE; while busy is high start is
// dropped (no queuing). A unit done is only honoured in the wait state for
// that unit; any other done pulse is ignored.
module muldiv_scheduler
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             mult_start,
  output logic             div_start,
  input  logic             mult_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             hi_w,
  output logic             lo_w,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout_err,
  output logic             unit_abort,
  output state_e           dbg_state_o,
  output logic [1:0]       dbg_op_o,
  output logic [WIDTH-1:0] dbg_a_o,
  output logic [WIDTH-1:0] dbg_b_o
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             in_wait, expired;

  assign in_wait = (state_q == WAIT_MUL) || (state_q == WAIT_DIV);

  // Held clear outside the wait states, so the count is 0 on wait entry.
  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (!in_wait),
    .enable_i  (in_wait),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mult_start  = 1'b0;
    div_start   = 1'b0;
    hi_w        = 1'b0;
    lo_w        = 1'b0;
    done        = 1'b0;
    div_zero    = 1'b0;
    timeout_err = 1'b0;
    unit_abort  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && ((op == OP_MULT) || (op == OP_DIV) || (op == OP_DIVM))) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_q == OP_MULT) begin
          mult_start = 1'b1;
          state_d    = WAIT_MUL;
        end else if (b_q == '0) begin
          // Divide by zero never reaches the divider.
          div_zero = 1'b1;
          state_d  = IDLE;
        end else begin
          div_start = 1'b1;
          state_d   = WAIT_DIV;
        end
      end
      // Done is tested before expiry so a done on the last count still wins.
      WAIT_MUL: begin
        if (mult_done) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          state_d = WRITE;
        end else if (expired) begin
          state_d = ERR;
        end
      end
      WAIT_DIV: begin
        if (div_done) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          state_d = WRITE;
        end else if (expired) begin
          state_d = ERR;
        end
      end
      WRITE: begin
        hi_w    = 1'b1;
        lo_w    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        timeout_err = 1'b1;
        unit_abort  = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Write data always shows the last captured result; hi_w/lo_w qualify it.
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;
  assign dbg_op_o    = op_q;
  assign dbg_a_o     = a_q;
  assign dbg_b_o     = b_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Bench for muldiv_scheduler. Two instances share clock, reset and unit-side
// inputs: u_dut uses the default TIMEOUT, u_dut_to uses TIMEOUT=8. Each has
// its own start line so only one of them is ever working at a time.
module tb_muldiv_scheduler;
  import muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        start_m, start_t;
  logic [1:0]  op;
  logic [31:0] a_in, b_in;
  logic        mult_done, div_done;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  // ---------------- outputs: main instance ----------------
  logic        m_mult_start, m_div_start, m_hi_w, m_lo_w, m_busy, m_done;
  logic        m_div_zero, m_timeout_err, m_unit_abort;
  logic [31:0] m_hi_out, m_lo_out, m_dbg_a, m_dbg_b;
  logic [1:0]  m_dbg_op;
  state_e      m_state;

  // ---------------- outputs: TIMEOUT=8 instance ----------------
  logic        t_mult_start, t_div_start, t_hi_w, t_lo_w, t_busy, t_done;
  logic        t_div_zero, t_timeout_err, t_unit_abort;
  logic [31:0] t_hi_out, t_lo_out, t_dbg_a, t_dbg_b;
  logic [1:0]  t_dbg_op;
  state_e      t_state;

  muldiv_scheduler u_dut (
    .clk(clk), .reset(reset), .start(start_m), .op(op), .a_in(a_in), .b_in(b_in),
    .mult_start(m_mult_start), .div_start(m_div_start),
    .mult_done(mult_done), .div_done(div_done),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi_w(m_hi_w), .lo_w(m_lo_w), .hi_out(m_hi_out), .lo_out(m_lo_out),
    .busy(m_busy), .done(m_done), .div_zero(m_div_zero),
    .timeout_err(m_timeout_err), .unit_abort(m_unit_abort),
    .dbg_state_o(m_state), .dbg_op_o(m_dbg_op), .dbg_a_o(m_dbg_a), .dbg_b_o(m_dbg_b)
  );

  muldiv_scheduler #(.WIDTH(32), .TIMEOUT(8)) u_dut_to (
    .clk(clk), .reset(reset), .start(start_t), .op(op), .a_in(a_in), .b_in(b_in),
    .mult_start(t_mult_start), .div_start(t_div_start),
    .mult_done(mult_done), .div_done(div_done),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi_w(t_hi_w), .lo_w(t_lo_w), .hi_out(t_hi_out), .lo_out(t_lo_out),
    .busy(t_busy), .done(t_done), .div_zero(t_div_zero),
    .timeout_err(t_timeout_err), .unit_abort(t_unit_abort),
    .dbg_state_o(t_state), .dbg_op_o(t_dbg_op), .dbg_a_o(t_dbg_a), .dbg_b_o(t_dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_t_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every HI/LO write must match the oldest expected {hi,lo} entry.
  always @(negedge clk) begin
    logic [63:0] e;
    if (m_hi_w) begin
      if (exp_q.size() == 0) check("m_unexpected_write", m_hi_w, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("m_write_data", {m_hi_out, m_lo_out}, e);
      end
    end
    if (t_hi_w) begin
      if (exp_t_q.size() == 0) check("t_unexpected_write", t_hi_w, 1'b0);
      else begin
        e = exp_t_q.pop_front();
        check("t_write_data", {t_hi_out, t_lo_out}, e);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;     // cycles from unit start to unit done
    logic        inject;  // pulse the other unit's done during the wait
    logic        exp_ms;
    logic        exp_ds;
    logic        exp_dz;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input int lat, input logic inj, input logic ms, input logic ds,
                              input logic dz, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.lat = lat; v.inject = inj;
    v.exp_ms = ms; v.exp_ds = ds; v.exp_dz = dz; v.exp_hi = hi; v.exp_lo = lo;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 = start, cycle 1 = ISSUE, unit done at cycle 1+lat.
  task automatic run_vec(input vec_t v);
    logic launched;
    launched = v.exp_ms || v.exp_ds;
    tick();
    check("idle_before_start", m_busy, 1'b0);
    start_m = 1'b1; op = v.op; a_in = v.a; b_in = v.b;
    tick();
    start_m = 1'b0; a_in = $urandom; b_in = $urandom;
    check("issue_mult_start", m_mult_start, v.exp_ms);
    check("issue_div_start", m_div_start, v.exp_ds);
    check("issue_div_zero", m_div_zero, v.exp_dz);
    check("issue_busy", m_busy, (v.op != 2'b11));
    if (v.op != 2'b11) check("latched_operands", {m_dbg_a, m_dbg_b}, {v.a, v.b});
    if (!launched) begin
      tick();
      check("no_launch_back_idle", {m_busy, m_div_zero, m_hi_w, m_done}, 4'b0000);
      return;
    end
    for (int i = 1; i < v.lat; i++) begin
      tick();
      mult_done = 1'b0; div_done = 1'b0;
      check("wait_no_write", {m_busy, m_hi_w, m_mult_start, m_div_start}, 4'b1000);
      if (v.inject && i == 1) begin
        if (v.exp_ms) begin div_done = 1'b1; div_hi = 32'hDEAD; div_lo = 32'hBEEF; end
        else begin mult_done = 1'b1; mult_hi = 32'hDEAD; mult_lo = 32'hBEEF; end
      end
    end
    tick();
    mult_done = 1'b0; div_done = 1'b0;
    if (v.exp_ms) begin mult_done = 1'b1; mult_hi = v.exp_hi; mult_lo = v.exp_lo; end
    else begin div_done = 1'b1; div_hi = v.exp_hi; div_lo = v.exp_lo; end
    exp_q.push_back({v.exp_hi, v.exp_lo});
    tick();
    mult_done = 1'b0; div_done = 1'b0;
    mult_hi = $urandom; mult_lo = $urandom; div_hi = $urandom; div_lo = $urandom;
    check("write_pulse", {m_hi_w, m_lo_w, m_done, m_busy}, 4'b1111);
    tick();
    check("after_write_idle", {m_busy, m_hi_w, m_done}, 3'b000);
    check("hilo_stable", {m_hi_out, m_lo_out}, {v.exp_hi, v.exp_lo});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    logic [63:0] prod;
    start_m = 0; start_t = 0; op = 0; a_in = 0; b_in = 0;
    mult_done = 0; div_done = 0; mult_hi = 0; mult_lo = 0; div_hi = 0; div_lo = 0;

    repeat (3) tick();
    check("in_reset_outputs", {m_busy, m_hi_w, m_done, m_mult_start, m_div_start, m_div_zero},
          6'b0);
    check("in_reset_state", m_state, IDLE);
    reset = 1'b1;
    tick();
    check("post_reset_hilo", {m_hi_out, m_lo_out}, 64'd0);
    check("post_reset_status", {m_busy, m_timeout_err, m_unit_abort, t_busy}, 4'b0);

    vecs[0] = mk(OP_MULT, 32'd7, 32'd6, 33, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd42);
    vecs[1] = mk(OP_DIV, 32'd100, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    vecs[2] = mk(OP_DIV, 32'd100, 32'd7, 10, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 32'd14);
    vecs[3] = mk(2'b11, 32'd5, 32'd5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[4] = mk(OP_DIVM, 32'hFFFF_FFFF, 32'd16, 5, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF, 32'h0FFF_FFFF);
    vecs[5] = mk(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFE);
    vecs[6] = mk(OP_DIVM, 32'd9, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    ra = $urandom; rb = $urandom;
    prod = 64'(ra) * 64'(rb);
    vecs[7] = mk(OP_MULT, ra, rb, int'($urandom_range(2, 20)), 1'b1, 1'b1, 1'b0, 1'b0,
                 prod[63:32], prod[31:0]);
    ra = $urandom; rb = $urandom_range(1, 1000);
    vecs[8] = mk(OP_DIV, ra, rb, int'($urandom_range(2, 20)), 1'b0, 1'b0, 1'b1, 1'b0,
                 ra % rb, ra / rb);
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // start during WAIT_DIV is dropped
    tick(); start_m = 1; op = OP_DIV; a_in = 32'd9; b_in = 32'd2;
    tick(); start_m = 0;
    check("seqA_div_start", m_div_start, 1'b1);
    tick();
    tick(); start_m = 1; op = OP_MULT; a_in = 32'd1; b_in = 32'd1;
    tick(); start_m = 0;
    check("seqA_start_ignored", {m_mult_start, m_dbg_a}, {1'b0, 32'd9});
    check("seqA_still_wait_div", m_state, WAIT_DIV);
    tick();
    tick(); div_done = 1; div_hi = 32'd1; div_lo = 32'd4; exp_q.push_back({32'd1, 32'd4});
    tick(); div_done = 0;
    check("seqA_write", m_hi_w, 1'b1);
    tick();
    check("seqA_no_second_op", {m_busy, m_mult_start}, 2'b00);

    // reset in the middle of WAIT_MUL, then a stale mult_done
    tick(); start_m = 1; op = OP_MULT; a_in = 32'd3; b_in = 32'd5;
    tick(); start_m = 0;
    check("seqB_mult_start", m_mult_start, 1'b1);
    tick(); tick(); tick();
    check("seqB_in_wait_mul", m_state, WAIT_MUL);
    reset = 1'b0;
    #1;
    check("seqB_async_idle", {m_busy, m_state}, {1'b0, IDLE});
    check("seqB_cleared_regs", {m_dbg_a, m_dbg_b, m_hi_out, m_lo_out}, 128'd0);
    tick(); reset = 1'b1;
    tick(); mult_done = 1; mult_hi = 32'd0; mult_lo = 32'd15;
    tick(); mult_done = 0;
    check("seqB_stale_done_ignored", {m_hi_w, m_done, m_busy, m_lo_out}, {3'b000, 32'd0});

    // TIMEOUT=8: no done -> ERR at cycle 10
    tick(); start_t = 1; op = OP_MULT; a_in = 32'd2; b_in = 32'd3;
    tick(); start_t = 0;
    check("seqT1_mult_start", t_mult_start, 1'b1);
    for (int c = 2; c <= 9; c++) begin
      tick();
      check("seqT1_waiting", {t_busy, t_timeout_err, t_unit_abort}, 3'b100);
    end
    tick();
    check("seqT1_err_pulse", {t_timeout_err, t_unit_abort, t_hi_w, t_done}, 4'b1100);
    tick();
    check("seqT1_back_idle", {t_busy, t_timeout_err, t_unit_abort}, 3'b000);

    // TIMEOUT=8: done on the final count cycle wins
    tick(); start_t = 1; op = OP_DIV; a_in = 32'd50; b_in = 32'd5;
    tick(); start_t = 0;
    check("seqT2_div_start", t_div_start, 1'b1);
    for (int c = 2; c <= 8; c++) tick();
    tick();
    check("seqT2_last_count_wait", {t_state, t_timeout_err}, {WAIT_DIV, 1'b0});
    div_done = 1; div_hi = 32'd0; div_lo = 32'd10; exp_t_q.push_back({32'd0, 32'd10});
    tick(); div_done = 0;
    check("seqT2_write_not_err", {t_hi_w, t_done, t_timeout_err, t_unit_abort}, 4'b1100);
    tick();
    check("seqT2_back_idle", {t_busy, m_busy}, 2'b00);

    tick();
    check("m_queue_drained", exp_q.size(), 0);
    check("t_queue_drained", exp_t_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: still running at %0t, required finish before 200000", $time);
    $fatal(1, "time limit");
  end

endmodule
